// File: rtl/cave_mem_pkg.sv
// Shared widths and arbiter state type for the cave memory read path.
package cave_mem_pkg;

  localparam int ADDR_WIDTH = 25;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA
  } arb_state_t;

endpackage

// File: rtl/read_port_arbiter_if.sv
// Wait/valid read-memory port: requester drives rd/addr, memory answers wait_n/valid/dout.
interface read_port_arbiter_if #(
  parameter int ADDR_WIDTH = cave_mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cave_mem_pkg::DATA_WIDTH
);

  logic                  rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  wait_n;
  logic                  valid;

  modport master (output rd, addr, input dout, wait_n, valid);
  modport slave  (input rd, addr, output dout, wait_n, valid);

endinterface

// File: rtl/read_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to rrPtr.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rrPtr,
  output logic       gntValid,
  output logic       gntIdx
);

  always_comb begin
    gntValid = |req;
    gntIdx   = 1'b0;
    case (req)
      2'b01:   gntIdx = 1'b0;
      2'b10:   gntIdx = 1'b1;
      2'b11:   gntIdx = rrPtr;
      default: gntIdx = 1'b0;
    endcase
  end

endmodule

// File: rtl/read_port_arbiter.sv
// Shares one wait/valid read port between two requesters; one outstanding
// read at a time, each returning BURST_LEN beats before re-arbitration.
module read_port_arbiter #(
  parameter int ADDR_WIDTH = cave_mem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cave_mem_pkg::DATA_WIDTH,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  read_port_arbiter_if.slave         io_in0,
  read_port_arbiter_if.slave         io_in1,
  read_port_arbiter_if.master        io_out,
  output logic                       io_busy
);

  import cave_mem_pkg::*;

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_t            state, stateNext;
  logic                  grant, grantNext;
  logic                  rrPtr, rrPtrNext;
  logic [CNT_W-1:0]      beatCnt, beatNext;
  logic [ADDR_WIDTH-1:0] addrReg, addrNext;
  logic                  accept, forward;
  logic                  gntValid, gntIdx;
  logic [DATA_WIDTH-1:0] beatData;

  rr_arbiter2 u_rr (
    .req      ({io_in1.rd, io_in0.rd}),
    .rrPtr    (rrPtr),
    .gntValid (gntValid),
    .gntIdx   (gntIdx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      rrPtr   <= 1'b0;
      beatCnt <= '0;
      addrReg <= '0;
    end else begin
      state   <= stateNext;
      grant   <= grantNext;
      rrPtr   <= rrPtrNext;
      beatCnt <= beatNext;
      addrReg <= addrNext;
    end
  end

  // A beat arriving in the acceptance cycle itself counts as beat 0.
  always_comb begin
    stateNext = state;
    grantNext = grant;
    rrPtrNext = rrPtr;
    beatNext  = beatCnt;
    addrNext  = addrReg;
    accept    = 1'b0;
    forward   = 1'b0;
    case (state)
      IDLE: begin
        if (gntValid) begin
          grantNext = gntIdx;
          addrNext  = gntIdx ? io_in1.addr : io_in0.addr;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (io_out.wait_n) begin
          accept    = 1'b1;
          forward   = 1'b1;
          beatNext  = '0;
          stateNext = DATA;
          if (io_out.valid) begin
            if (BURST_LEN == 1) begin
              stateNext = IDLE;
              rrPtrNext = ~grant;
            end else begin
              beatNext = CNT_W'(1);
            end
          end
        end
      end
      DATA: begin
        forward = 1'b1;
        if (io_out.valid) begin
          if (beatCnt == LAST_BEAT) begin
            stateNext = IDLE;
            rrPtrNext = ~grant;
          end else begin
            beatNext = beatCnt + CNT_W'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign beatData      = io_out.dout;
  assign io_in0.dout   = beatData;
  assign io_in1.dout   = beatData;
  assign io_in0.valid  = io_out.valid & forward & ~grant;
  assign io_in1.valid  = io_out.valid & forward & grant;
  assign io_in0.wait_n = accept & ~grant;
  assign io_in1.wait_n = accept & grant;
  assign io_out.rd     = (state == REQ);
  assign io_out.addr   = addrReg;
  assign io_busy       = (state != IDLE);

endmodule

// File: tb/tb_read_port_arbiter.sv
// Self-checking bench for read_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_read_port_arbiter;

  import cave_mem_pkg::*;

  localparam int BL = 4;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  int   nChecks = 0;
  int   nFail   = 0;

  read_port_arbiter_if in0 ();
  read_port_arbiter_if in1 ();
  read_port_arbiter_if mem ();

  read_port_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .io_in0  (in0),
    .io_in1  (in1),
    .io_out  (mem),
    .io_busy (busy)
  );

  always #5 clock = ~clock;

  // Control outputs packed as {busy, out_rd, in0_wait_n, in0_valid, in1_wait_n, in1_valid}.
  function automatic logic [5:0] outVec();
    return {busy, mem.rd, in0.wait_n, in0.valid, in1.wait_n, in1.valid};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    in0.rd = 1'b0; in0.addr = '0;
    in1.rd = 1'b0; in1.addr = '0;
    mem.dout = '0; mem.wait_n = 1'b0; mem.valid = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    in0.rd = 1'b1; in1.rd = 1'b1;
    mem.wait_n = 1'b1; mem.valid = 1'b1; mem.dout = 8'h3C;
    step();
    step();
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL reset_ctrl: got %b want %b", outVec(), 6'b000000); end
    nChecks++; if (mem.addr !== '0) begin nFail++; $display("[TB] FAIL reset_addr: got %h want 0", mem.addr); end
    nChecks++; if (in0.dout !== 8'h3C || in1.dout !== 8'h3C) begin nFail++; $display("[TB] FAIL reset_dout: got %h/%h want 3c", in0.dout, in1.dout); end
    reset = 1'b0;
    idleInputs();
  endtask

  task automatic test_single_read();
    doReset();
    in0.rd = 1'b1; in0.addr = 25'h0001234;
    #1;
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL single_idle: got %b want %b", outVec(), 6'b000000); end
    for (int i = 0; i < 2; i++) begin
      step();
      nChecks++; if (outVec() !== 6'b110000) begin nFail++; $display("[TB] FAIL single_req: got %b want %b", outVec(), 6'b110000); end
      nChecks++; if (mem.addr !== 25'h0001234) begin nFail++; $display("[TB] FAIL single_addr: got %h want 0001234", mem.addr); end
    end
    step();
    mem.wait_n = 1'b1;
    #1;
    nChecks++; if (outVec() !== 6'b111000) begin nFail++; $display("[TB] FAIL single_accept: got %b want %b", outVec(), 6'b111000); end
    step();
    in0.rd = 1'b0; mem.wait_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        mem.valid = 1'b0;
        #1;
        nChecks++; if (outVec() !== 6'b100000) begin nFail++; $display("[TB] FAIL single_gap: got %b want %b", outVec(), 6'b100000); end
        step();
      end
      mem.valid = 1'b1; mem.dout = 8'hA0 + 8'(i);
      #1;
      nChecks++; if (outVec() !== 6'b100100) begin nFail++; $display("[TB] FAIL single_beat%0d: got %b want %b", i, outVec(), 6'b100100); end
      nChecks++; if (in0.dout !== 8'hA0 + 8'(i)) begin nFail++; $display("[TB] FAIL single_data%0d: got %h want %h", i, in0.dout, 8'hA0 + 8'(i)); end
      step();
    end
    mem.valid = 1'b0;
    #1;
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL single_done: got %b want %b", outVec(), 6'b000000); end
  endtask

  task automatic test_tie();
    int   waitCnt;
    logic owner;
    doReset();
    in0.rd = 1'b1; in0.addr = 25'h10;
    in1.rd = 1'b1; in1.addr = 25'h20;
    for (int b = 0; b < 3; b++) begin
      owner = (b % 2) == 1;
      waitCnt = 0;
      while (mem.rd !== 1'b1 && waitCnt < 8) begin
        step();
        waitCnt++;
      end
      nChecks++; if (mem.rd !== 1'b1) begin nFail++; $display("[TB] FAIL tie_timeout burst %0d: got rd=%b want 1", b, mem.rd); end
      nChecks++; if (mem.addr !== (owner ? 25'h20 : 25'h10)) begin nFail++; $display("[TB] FAIL tie_addr burst %0d: got %h want %h", b, mem.addr, owner ? 25'h20 : 25'h10); end
      mem.wait_n = 1'b1;
      #1;
      nChecks++; if ({in0.wait_n, in1.wait_n} !== (owner ? 2'b01 : 2'b10)) begin nFail++; $display("[TB] FAIL tie_wait burst %0d: got %b want %b", b, {in0.wait_n, in1.wait_n}, owner ? 2'b01 : 2'b10); end
      step();
      mem.wait_n = 1'b0;
      for (int k = 0; k < BL; k++) begin
        mem.valid = 1'b1; mem.dout = 8'(16 * b + k);
        #1;
        nChecks++; if ({in0.valid, in1.valid} !== (owner ? 2'b01 : 2'b10)) begin nFail++; $display("[TB] FAIL tie_valid burst %0d beat %0d: got %b want %b", b, k, {in0.valid, in1.valid}, owner ? 2'b01 : 2'b10); end
        step();
      end
      mem.valid = 1'b0;
    end
    idleInputs();
  endtask

  task automatic test_zero_latency();
    doReset();
    in1.rd = 1'b1; in1.addr = 25'h77;
    step();
    mem.wait_n = 1'b1; mem.valid = 1'b1; mem.dout = 8'hB0;
    #1;
    nChecks++; if (outVec() !== 6'b110011) begin nFail++; $display("[TB] FAIL zl_accept: got %b want %b", outVec(), 6'b110011); end
    step();
    in1.rd = 1'b0; mem.wait_n = 1'b0;
    for (int k = 1; k < BL; k++) begin
      mem.dout = 8'hB0 + 8'(k);
      #1;
      nChecks++; if (outVec() !== 6'b100001) begin nFail++; $display("[TB] FAIL zl_beat%0d: got %b want %b", k, outVec(), 6'b100001); end
      step();
    end
    #1;
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL zl_extra: got %b want %b", outVec(), 6'b000000); end
    mem.valid = 1'b0;
  endtask

  task automatic test_spurious_valid();
    doReset();
    mem.valid = 1'b1; mem.dout = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL sp_idle: got %b want %b", outVec(), 6'b000000); end
      nChecks++; if (in0.dout !== 8'h55 || in1.dout !== 8'h55) begin nFail++; $display("[TB] FAIL sp_dout: got %h/%h want 55", in0.dout, in1.dout); end
      step();
    end
    in0.rd = 1'b1; in0.addr = 25'h5;
    step();
    #1;
    nChecks++; if (outVec() !== 6'b110000) begin nFail++; $display("[TB] FAIL sp_req: got %b want %b", outVec(), 6'b110000); end
    mem.wait_n = 1'b1; mem.valid = 1'b0;
    step();
    in0.rd = 1'b0; mem.wait_n = 1'b0;
    for (int k = 0; k < BL; k++) begin
      mem.valid = 1'b1; mem.dout = 8'(k);
      #1;
      nChecks++; if (outVec() !== 6'b100100) begin nFail++; $display("[TB] FAIL sp_beat%0d: got %b want %b", k, outVec(), 6'b100100); end
      step();
    end
    mem.valid = 1'b0;
    #1;
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL sp_end: got %b want %b", outVec(), 6'b000000); end
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    in0.rd = 1'b1; in0.addr = 25'h40;
    step();
    mem.wait_n = 1'b1;
    step();
    in0.rd = 1'b0; mem.wait_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem.valid = 1'b1; mem.dout = 8'(k);
      step();
    end
    mem.valid = 1'b1; mem.dout = 8'h99;
    #1;
    nChecks++; if (outVec() !== 6'b100100) begin nFail++; $display("[TB] FAIL rst_pre: got %b want %b", outVec(), 6'b100100); end
    reset = 1'b1;
    #1;
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL rst_async: got %b want %b", outVec(), 6'b000000); end
    nChecks++; if (mem.addr !== '0) begin nFail++; $display("[TB] FAIL rst_addr: got %h want 0", mem.addr); end
    nChecks++; if (in0.dout !== 8'h99) begin nFail++; $display("[TB] FAIL rst_dout: got %h want 99", in0.dout); end
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL rst_stray%0d: got %b want %b", k, outVec(), 6'b000000); end
      step();
    end
    mem.valid = 1'b0;
    in1.rd = 1'b1; in1.addr = 25'h123;
    step();
    #1;
    nChecks++; if (outVec() !== 6'b110000) begin nFail++; $display("[TB] FAIL rst_req1: got %b want %b", outVec(), 6'b110000); end
    nChecks++; if (mem.addr !== 25'h123) begin nFail++; $display("[TB] FAIL rst_addr1: got %h want 0000123", mem.addr); end
    mem.wait_n = 1'b1;
    #1;
    nChecks++; if (outVec() !== 6'b110010) begin nFail++; $display("[TB] FAIL rst_acc1: got %b want %b", outVec(), 6'b110010); end
    step();
    in1.rd = 1'b0; mem.wait_n = 1'b0;
    for (int k = 0; k < BL; k++) begin
      mem.valid = 1'b1;
      #1;
      nChecks++; if (outVec() !== 6'b100001) begin nFail++; $display("[TB] FAIL rst_beat%0d: got %b want %b", k, outVec(), 6'b100001); end
      step();
    end
    mem.valid = 1'b0;
    #1;
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL rst_end: got %b want %b", outVec(), 6'b000000); end
  endtask

  task automatic test_drop_rd();
    doReset();
    in0.rd = 1'b1; in0.addr = 25'h3A;
    step();
    in0.rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++; if (outVec() !== 6'b110000) begin nFail++; $display("[TB] FAIL drop_req%0d: got %b want %b", i, outVec(), 6'b110000); end
      step();
    end
    mem.wait_n = 1'b1;
    #1;
    nChecks++; if (outVec() !== 6'b111000) begin nFail++; $display("[TB] FAIL drop_accept: got %b want %b", outVec(), 6'b111000); end
    step();
    mem.wait_n = 1'b0;
    for (int k = 0; k < BL; k++) begin
      mem.valid = 1'b1;
      #1;
      nChecks++; if (outVec() !== 6'b100100) begin nFail++; $display("[TB] FAIL drop_beat%0d: got %b want %b", k, outVec(), 6'b100100); end
      step();
    end
    mem.valid = 1'b0;
    #1;
    nChecks++; if (outVec() !== 6'b000000) begin nFail++; $display("[TB] FAIL drop_end: got %b want %b", outVec(), 6'b000000); end
  endtask

  // Reference model tracks one read as "issued, not yet accepted" plus a
  // count of beats still owed, and a preferred winner for the next tie.
  task automatic test_random();
    logic                  mIssue, mOwner, mPref;
    int                    mBeats;
    logic [ADDR_WIDTH-1:0] mAddr;
    logic                  pend0, pend1, acc, recv, w0e, w1e;
    logic [5:0]            expV;
    doReset();
    mIssue = 1'b0; mBeats = 0; mOwner = 1'b0; mPref = 1'b0; mAddr = '0;
    pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!pend0 && $urandom_range(0, 2) == 0) begin pend0 = 1'b1; in0.addr = ADDR_WIDTH'($urandom); end
      if (!pend1 && $urandom_range(0, 2) == 0) begin pend1 = 1'b1; in1.addr = ADDR_WIDTH'($urandom); end
      in0.rd = pend0; in1.rd = pend1;
      mem.wait_n = 1'($urandom_range(0, 1));
      mem.valid  = ($urandom_range(0, 4) != 0);
      mem.dout   = 8'($urandom);
      @(negedge clock);
      if (reset) begin
        mIssue = 1'b0; mBeats = 0; mOwner = 1'b0; mPref = 1'b0; mAddr = '0;
      end
      acc  = mIssue && mem.wait_n;
      recv = (mBeats > 0) || acc;
      w0e  = acc && !mOwner;
      w1e  = acc && mOwner;
      expV = {(mIssue || mBeats > 0), mIssue, w0e, (mem.valid && recv && !mOwner), w1e, (mem.valid && recv && mOwner)};
      nChecks++; if (outVec() !== expV) begin nFail++; $display("[TB] FAIL rand_ctrl cycle %0d: got %b want %b", c, outVec(), expV); end
      nChecks++; if (mem.addr !== mAddr) begin nFail++; $display("[TB] FAIL rand_addr cycle %0d: got %h want %h", c, mem.addr, mAddr); end
      nChecks++; if (in0.dout !== mem.dout || in1.dout !== mem.dout) begin nFail++; $display("[TB] FAIL rand_dout cycle %0d: got %h/%h want %h", c, in0.dout, in1.dout, mem.dout); end
      @(posedge clock);
      if (!reset) begin
        if (mIssue || mBeats > 0) begin
          if (acc) begin
            mIssue = 1'b0;
            mBeats = BL;
          end
          if (mem.valid && recv) begin
            mBeats--;
            if (mBeats == 0) mPref = !mOwner;
          end
        end else if (in0.rd || in1.rd) begin
          mOwner = (in0.rd && in1.rd) ? mPref : in1.rd;
          mAddr  = mOwner ? in1.addr : in0.addr;
          mIssue = 1'b1;
        end
      end
      if (w0e) pend0 = 1'b0;
      if (w1e) pend1 = 1'b0;
      #1;
    end
    reset = 1'b0;
    idleInputs();
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    test_reset();
    test_single_read();
    test_tie();
    test_zero_latency();
    test_spurious_valid();
    test_reset_mid_burst();
    test_drop_rd();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/read_port_arbiter.md
Name: read_port_arbiter

Overview:
- Shares one wait/valid read-memory port between two requesters, e.g. two sprite/tile fetchers feeding a single ROM channel.
- Round-robin grant; exactly one outstanding read at a time.
- Each read returns BURST_LEN data beats before the port is re-arbitrated.
- Sits upstream of the clock-domain read freezer / memory multiplexer.

Parameters:
ADDR_WIDTH, 25, address width of all ports
DATA_WIDTH, 8, data width of all ports
BURST_LEN, 4, valid beats returned per accepted read (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
io_in0_rd  in  1  requester 0 read request (held until wait_n)
io_in0_addr  in  ADDR_WIDTH  requester 0 address
io_in0_dout  out  DATA_WIDTH  requester 0 read data
io_in0_wait_n  out  1  requester 0 request accepted
io_in0_valid  out  1  requester 0 data beat valid
io_in1_rd, io_in1_addr, io_in1_dout, io_in1_wait_n, io_in1_valid  same as requester 0, for requester 1
io_out_rd  out  1  memory read request
io_out_addr  out  ADDR_WIDTH  memory address
io_out_dout  in  DATA_WIDTH  memory read data
io_out_wait_n  in  1  memory accepted request
io_out_valid  in  1  memory data beat valid
io_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high (reset).
- Reset state: IDLE, grant=0, rrPtr=0, beatCnt=0, addrReg=0.
- Outputs during reset: all outputs 0, except io_inN_dout, which follows io_out_dout.

State machine (IDLE, REQ, DATA), registered:
- IDLE
  - If only one rd is high, latch that index into grant and its addr into addrReg.
  - If both are high, pick index == rrPtr.
  - Next state REQ. No rd: stay IDLE.
- REQ
  - io_out_rd=1, io_out_addr=addrReg.
  - When io_out_wait_n=1: io_inG_wait_n=1 for that single cycle (G = grant), beatCnt=0, next state DATA.
- DATA
  - Each io_out_valid=1 is forwarded as io_inG_valid=1 and increments beatCnt.
  - On the beat where beatCnt==BURST_LEN-1: next state IDLE, rrPtr = ~grant.

Combinational forwarding:
- io_in0_dout = io_in1_dout = io_out_dout (broadcast).
- io_inN_valid = io_out_valid & (inDATA-or-accept-cycle) & (grant==N).
- io_inN_wait_n = 0 except the acceptance cycle of the granted requester.
- io_out_rd = 0 outside REQ.
- io_out_addr = addrReg at all times.

Latency:
- rd high in IDLE -> io_out_rd high next cycle.
- Minimum one idle bubble between the last beat of a burst and the next io_out_rd.

Boundary cases:
- io_out_valid in the REQ acceptance cycle (zero-latency memory): forwarded to the granted requester and counted as beat 0. If BURST_LEN==1, return to IDLE directly.
- io_out_valid in IDLE, or in REQ before acceptance: dropped, not counted, no requester sees valid.
- Granted requester drops rd while in REQ: the read is still issued and completed (no abort). Requesters must hold rd and addr until wait_n.
- Non-granted requester raising rd during REQ/DATA: waits, wait_n=0; considered at the next IDLE.
- Both requesting continuously: grants alternate 0,1,0,1. After reset, 0 wins the first tie.
- beatCnt width: clog2(BURST_LEN) bits, minimum 1; never wraps, because it resets on entry to DATA.
- Reset asserted mid-burst: immediate return to IDLE, io_out_rd=0, rrPtr=0. Remaining memory beats after release arrive in IDLE and are dropped.

Decomposition:
- Shared package (cave_mem_pkg): ADDR_WIDTH/DATA_WIDTH constants, and the arb_state_t enum {IDLE, REQ, DATA}.
- Natural sub-module: rr_arbiter2 (2-way round-robin priority pick from rd vector plus rrPtr).
- Beat counter and forwarding stay in the top module.

Test Plan:
- Single read: in0_rd=1, addr=0x0001234. Memory accepts after 2 cycles and returns 4 beats 0xA0..0xA3.
  -> out_addr=0x0001234; in0_wait_n pulses once; in0_valid x4 with those data; in1_valid never high; busy drops the cycle after beat 3.
- Tie: in0 and in1 both rd from reset, addrs 0x10/0x20.
  -> first out_addr=0x10, then 0x20, then 0x10; each burst's 4 valids go only to its owner.
- Zero-latency memory: wait_n and valid both high in the acceptance cycle, then 3 more beats.
  -> 4 beats counted; return to IDLE after the 4th; no extra beat forwarded.
- Spurious valid: io_out_valid=1 in IDLE with data 0x55.
  -> neither in*_valid asserts; beatCnt unchanged.
- Reset mid-burst: assert reset after beat 1 of 4.
  -> outputs 0 asynchronously. After release, 2 stray valids are dropped. The next in1 request is granted normally with 4 beats.
- Requester drops rd in REQ before wait_n.
  -> out_rd stays high until accepted; burst completes to requester 0.
